// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared writeback entry type, source encodings and ROB age helpers
package wb_arbiter_pkg;

    localparam int ROB_W  = 5;
    localparam int PREG_W = 7;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_BR  = 2'd1,
        SRC_MEM = 2'd2
    } wb_src_t;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_tag;
        logic [PREG_W-1:0] pd;
        logic              has_dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Ages are distances from the ROB head, so the compare stays correct
    // when tags wrap past 2^ROB_W-1.
    function automatic logic is_younger(input logic [ROB_W-1:0] tag,
                                        input logic [ROB_W-1:0] ref_tag,
                                        input logic [ROB_W-1:0] head);
        logic [ROB_W-1:0] age_tag;
        logic [ROB_W-1:0] age_ref;
        age_tag = tag - head;
        age_ref = ref_tag - head;
        return age_tag > age_ref;
    endfunction

    function automatic wb_src_t next_src(input wb_src_t s);
        case (s)
            SRC_ALU: return SRC_BR;
            SRC_BR:  return SRC_MEM;
            default: return SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source result queue with push, pop, flush-by-age and count
//   clk, reset        : clock, synchronous active-high reset
//   push, push_entry  : enqueue request and payload
//   pop               : dequeue the surviving head this cycle
//   flush, flush_tag  : squash entries younger than flush_tag
//   rob_head          : ROB head tag used as the age origin
//   head_entry/valid  : oldest surviving entry (flush already applied)
//   count             : registered occupancy
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic             flush,
    input  logic [ROB_W-1:0] flush_tag,
    input  logic [ROB_W-1:0] rob_head,
    output wb_entry_t        head_entry,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    // Slot 0 is always the oldest entry; a pop shifts the queue down.
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        surv  [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [CNT_W-1:0] surv_cnt;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;

    // Survivors of a flush, compacted toward slot 0 in original order.
    always_comb begin
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            surv[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((i < int'(count)) &&
                !(flush && is_younger(mem_q[i].rob_tag, flush_tag, rob_head))) begin
                surv[n[IDX_W-1:0]] = mem_q[i];
                n = n + CNT_W'(1);
            end
        end
        surv_cnt = n;
    end

    assign head_entry = surv[0];
    assign head_valid = (surv_cnt != '0);
    assign push_ok    = push && !(flush && is_younger(push_entry.rob_tag, flush_tag, rob_head));

    always_comb begin
        logic [CNT_W-1:0] n;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = surv[i];
        end
        n = surv_cnt;
        if (pop && (n != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_d[i+1];
            end
            mem_d[DEPTH-1] = '0;
            n = n - CNT_W'(1);
        end
        // A push into a full queue is dropped; the stall protocol prevents it.
        if (push_ok && (n < CNT_W'(DEPTH))) begin
            mem_d[n[IDX_W-1:0]] = push_entry;
            n = n + CNT_W'(1);
        end
        count_d = n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback scheduler from ALU/branch/mem onto the CDB
//   clk, reset                 : clock, synchronous active-high reset
//   alu_*, b_*, mem_*          : FU results (valid, rob_tag, pd, has_dest, result)
//   rob_head                   : ROB head tag (age origin)
//   mispredict, mispredict_tag : squash results younger than the tag
//   alu_stall, b_stall, mem_stall : per-FU issue throttle
//   cdb_*                      : registered broadcast; cdb_src 0=ALU 1=branch 2=mem
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = wb_arbiter_pkg::PREG_W,
    parameter int ROB_W  = wb_arbiter_pkg::ROB_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_rob_tag,
    input  logic [PREG_W-1:0] alu_pd,
    input  logic              alu_has_dest,
    input  logic [31:0]       alu_result,
    input  logic              b_valid,
    input  logic [ROB_W-1:0]  b_rob_tag,
    input  logic [PREG_W-1:0] b_pd,
    input  logic              b_has_dest,
    input  logic [31:0]       b_result,
    input  logic              mem_valid,
    input  logic [ROB_W-1:0]  mem_rob_tag,
    input  logic [PREG_W-1:0] mem_pd,
    input  logic              mem_has_dest,
    input  logic [31:0]       mem_result,
    input  logic [ROB_W-1:0]  rob_head,
    input  logic              mispredict,
    input  logic [ROB_W-1:0]  mispredict_tag,
    output logic              alu_stall,
    output logic              b_stall,
    output logic              mem_stall,
    output logic              cdb_valid,
    output logic [ROB_W-1:0]  cdb_rob_tag,
    output logic [PREG_W-1:0] cdb_pd,
    output logic              cdb_has_dest,
    output logic [31:0]       cdb_data,
    output logic [1:0]        cdb_src
);

    import wb_arbiter_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [2:0]       in_valid;
    wb_entry_t        in_entry   [3];
    wb_entry_t        head_entry [3];
    logic [2:0]       head_valid;
    logic [CNT_W-1:0] fifo_cnt   [3];
    logic [2:0]       pop;

    wb_src_t          rr;
    wb_src_t          grant_src;
    logic             grant_any;
    wb_entry_t        cdb_q;
    wb_src_t          cdb_src_q;

    assign in_valid    = {mem_valid, b_valid, alu_valid};
    assign in_entry[0] = '{rob_tag: alu_rob_tag, pd: alu_pd, has_dest: alu_has_dest, data: alu_result};
    assign in_entry[1] = '{rob_tag: b_rob_tag,   pd: b_pd,   has_dest: b_has_dest,   data: b_result};
    assign in_entry[2] = '{rob_tag: mem_rob_tag, pd: mem_pd, has_dest: mem_has_dest, data: mem_result};

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push       (in_valid[g]),
            .push_entry (in_entry[g]),
            .pop        (pop[g]),
            .flush      (mispredict),
            .flush_tag  (mispredict_tag),
            .rob_head   (rob_head),
            .head_entry (head_entry[g]),
            .head_valid (head_valid[g]),
            .count      (fifo_cnt[g])
        );
    end

    // One slot stays free for a result already issued by a 1-cycle FU.
    assign alu_stall = (fifo_cnt[0] >= CNT_W'(DEPTH - 1));
    assign b_stall   = (fifo_cnt[1] >= CNT_W'(DEPTH - 1));
    assign mem_stall = (fifo_cnt[2] >= CNT_W'(DEPTH - 1));

    // head_valid already excludes squashed entries, so a flush edge only
    // arbitrates among survivors.
    always_comb begin
        wb_src_t cand;
        grant_any = 1'b0;
        grant_src = rr;
        cand      = rr;
        for (int k = 0; k < 3; k++) begin
            if (!grant_any && head_valid[cand]) begin
                grant_any = 1'b1;
                grant_src = cand;
            end
            cand = next_src(cand);
        end
    end

    assign pop = grant_any ? (3'b001 << grant_src) : 3'b000;

    // Any CDB content is replaced at every edge, so a younger result sitting
    // in the register is dropped on the flush edge without extra logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr        <= SRC_ALU;
            cdb_valid <= 1'b0;
            cdb_q     <= '0;
            cdb_src_q <= SRC_ALU;
        end else if (grant_any) begin
            rr        <= next_src(grant_src);
            cdb_valid <= 1'b1;
            cdb_q     <= head_entry[grant_src];
            cdb_src_q <= grant_src;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    assign cdb_rob_tag  = cdb_q.rob_tag;
    assign cdb_pd       = cdb_q.pd;
    assign cdb_has_dest = cdb_q.has_dest;
    assign cdb_data     = cdb_q.data;
    assign cdb_src      = cdb_src_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback scheduler between the three functional units (ALU, branch, memory) and the single common data bus (CDB) / PRF write port.
- Each FU result is captured in a per-source FIFO; one result per cycle is granted onto a registered CDB output using round-robin arbitration.
- Throttles RS issue per FU via almost-full stalls.
- Squashes queued results younger than a branch mispredict.

Parameters:
- DEPTH, 4, entries per source FIFO (power of 2, ≥2).
- PREG_W, 7, physical register index width.
- ROB_W, 5, ROB tag width (ROB has 2^ROB_W entries).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result valid this cycle
- alu_rob_tag  in  ROB_W  ALU result ROB tag
- alu_pd  in  PREG_W  ALU destination preg
- alu_has_dest  in  1  ALU result writes PRF
- alu_result  in  32  ALU result data
- b_valid, b_rob_tag, b_pd, b_has_dest, b_result  in  1/ROB_W/PREG_W/1/32  branch FU result, same meaning as ALU fields
- mem_valid, mem_rob_tag, mem_pd, mem_has_dest, mem_result  in  1/ROB_W/PREG_W/1/32  memory FU result, same meaning as ALU fields
- rob_head  in  ROB_W  current ROB head tag
- mispredict  in  1  flush request
- mispredict_tag  in  ROB_W  ROB tag of the mispredicting branch
- alu_stall  out  1  ALU RS must not issue
- b_stall  out  1  branch RS must not issue
- mem_stall  out  1  memory RS must not issue
- cdb_valid  out  1  broadcast valid
- cdb_rob_tag  out  ROB_W  broadcast ROB tag
- cdb_pd  out  PREG_W  broadcast destination preg
- cdb_has_dest  out  1  PRF write enable qualifier
- cdb_data  out  32  broadcast data
- cdb_src  out  2  granted source: 0 = ALU, 1 = branch, 2 = mem

Behaviour:
- Reset (synchronous, active-high):
  - All FIFOs empty; rr pointer = 0 (ALU highest priority next).
  - All cdb_* outputs = 0; all stalls = 0.
  - Reset overrides any simultaneous valid or mispredict.
- Enqueue:
  - Each *_valid=1 at the clock edge writes its payload to that source's FIFO tail.
  - All three sources may enqueue in the same cycle.
- Stall:
  - x_stall = (count_x >= DEPTH-1), taken from registered count.
  - One slot stays reserved for a result already in flight from a 1-cycle FU.
  - An enqueue to a full FIFO is dropped; this is a protocol violation and the bench asserts it never occurs.
- Arbitration, each cycle:
  - Among non-empty FIFOs, grant the first in order rr, rr+1, rr+2 (mod 3).
  - On grant: pop the head, load it into the CDB output register, set rr = granted+1 mod 3.
  - No grant: cdb_valid=0 next cycle, other cdb_* fields hold, rr unchanged.
- Latency:
  - Result enqueued into an empty FIFO at edge N, with no competition, appears with cdb_valid=1 in the cycle following edge N+1.
  - Minimum latency is 1 cycle after capture.
  - Same-cycle enqueue and pop on one FIFO is legal; count is unchanged.
  - Throughput: 1 result per cycle total.
- Flush (mispredict=1 at an edge):
  - age(t) = (t - rob_head) mod 2^ROB_W.
  - An entry is younger iff age(tag) > age(mispredict_tag).
  - Younger entries are removed from every FIFO; survivors keep their relative order. Implemented as a valid-bit-per-entry invalidate plus head skip, or compaction; either is acceptable provided ordering is preserved.
  - Younger incoming enqueues are not written.
  - A younger result that would be loaded into the CDB register is replaced by cdb_valid=0. A younger result already in the CDB register is cleared (cdb_valid=0) at the same edge.
  - The mispredicting branch itself (age equal) and older entries are kept.
  - Arbitration on a flush edge considers only surviving entries.
- Wrap-around:
  - FIFO pointers wrap mod DEPTH.
  - Age compare is correct across the ROB tag wrap (e.g. head=30, tag 1 is younger than tag 31).
- Count, full/empty:
  - Per-FIFO count width is clog2(DEPTH)+1.
  - Empty FIFOs are never granted.

Decomposition:
- Shared package (existing core package): wb_entry_t struct {rob_tag, pd, has_dest, data}; source encodings SRC_ALU=0, SRC_BR=1, SRC_MEM=2; ROB_W/PREG_W constants.
- One sub-module: wb_fifo (DEPTH-entry queue with push, pop, flush-by-age, count output), instantiated three times.
- Round-robin arbiter and CDB register live in the top.

Test Plan:
- ALU only: alu_valid with tag 3, pd 12, data 0xDEADBEEF → next cycle cdb_valid=1, tag 3, pd 12, data 0xDEADBEEF, src 0; following cycle cdb_valid=0.
- All three valid in the same cycle (tags 4, 5, 6), rr=0 → CDB order ALU, branch, mem on 3 consecutive cycles; rr returns to 0.
- Push 3 ALU results back-to-back while the CDB is contended by mem → alu_stall=1 once count reaches 3; clears after a pop; no entry lost.
- rob_head=28, FIFO tags {29, 31, 1}, mispredict_tag=31 → tag 1 squashed, 29 and 31 broadcast in order; CDB never shows tag 1.
- Register holds tag 2 from mem, mispredict_tag=0, head=30 → cdb_valid=0 on the flush edge; tag 0 itself still broadcasts.
- Reset asserted with all FIFOs non-empty and valid high → next cycle all outputs 0, FIFOs empty, stalls 0.
